shift_add_multiplier: RTL and testbench

Sequential unsigned multiplier that performs the reverse operation of the divider datapath. It computes Product = A × B using one shift-and-add iteration per clock. The block sits beside the divider in the ALSU arithmetic cluster and shares the same start/busy/done handshake. The result feeds the ALSU output mux.

---
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_shift_add_multiplier.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Sequential unsigned multiplier, one shift-and-add iteration per clock.
// Product = A * B is available WIDTH cycles after start is accepted.
//
// Handshake: start is sampled only while busy=0. An accepted start captures
// A and B, raises busy on the next cycle and keeps it high for WIDTH cycles.
// On the completion edge Product is updated, done pulses for one cycle and
// busy drops. A start in the done cycle is accepted (back-to-back).
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   operation request (ignored while busy)
//   A       multiplicand, WIDTH bits
//   B       multiplier, WIDTH bits
//   Product registered 2*WIDTH-bit result, holds until next completion/reset
//   busy    high while an operation is in progress
//   done    one-cycle pulse when Product updates
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Current FSM state, visible for checkers bound to this module.
  state_t state, state_n;

  logic [WIDTH-1:0]   m, m_n;
  logic [WIDTH:0]     acc, acc_n;
  logic [WIDTH-1:0]   q, q_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] product_n;
  logic               busy_n;
  logic               done_n;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      Product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      m       <= m_n;
      acc     <= acc_n;
      q       <= q_n;
      cnt     <= cnt_n;
      Product <= product_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    m_n       = m;
    acc_n     = acc;
    q_n       = q;
    cnt_n     = cnt;
    product_n = Product;
    busy_n    = busy;
    done_n    = 1'b0;
    // Partial-product add; ACC carries one extra bit so the add never overflows.
    sum       = acc + (q[0] ? {1'b0, m} : '0);

    case (state)
      IDLE: begin
        if (start) begin
          m_n     = A;
          q_n     = B;
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        // The consumed multiplier bit drops off the bottom of Q while the
        // lowest sum bit moves into the top of Q.
        {acc_n, q_n} = {sum, q} >> 1;
        cnt_n        = cnt + 1'b1;
        if (cnt == LAST) begin
          product_n = {acc_n[WIDTH-1:0], q_n};
          done_n    = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
// Self-checking bench for shift_add_multiplier (WIDTH=4). The reference model
// is plain multiplication: each accepted start pushes A*B onto an expected
// queue, and the result is popped and compared WIDTH cycles later.
module tb_shift_add_multiplier;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;

  int vectors;
  int miscompares;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_prod;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (a),
    .B       (b),
    .Product (product),
    .busy    (busy),
    .done    (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: present operands with start for one edge; the model records A*B.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(PW'(int'(av) * int'(bv)));
    tick();
    start = 1'b0;
  endtask

  // Run the WIDTH cycles of an operation. Operands wiggle every cycle; a
  // stray start is asserted on cycle `inject` (0 = none) and must be ignored.
  task automatic wait_done(input int inject);
    logic [PW-1:0] exp;
    for (int k = 1; k <= WIDTH; k++) begin
      a     = WIDTH'($urandom_range(0, 15));
      b     = WIDTH'($urandom_range(0, 15));
      start = (k == inject);
      tick();
      start = 1'b0;
      if (k < WIDTH) begin
        check("busy_calc", 16'(busy), 16'd1);
        check("done_calc", 16'(done), 16'd0);
        check("prod_hold", 16'(product), 16'(last_prod));
      end else begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 16'd0, 16'd1);
          exp = '0;
        end else begin
          exp = exp_q.pop_front();
        end
        check("done_pulse", 16'(done), 16'd1);
        check("busy_end", 16'(busy), 16'd0);
        check("product", 16'(product), 16'(exp));
        last_prod = exp;
      end
    end
  endtask

  task automatic idle_cycle();
    tick();
    check("done_low", 16'(done), 16'd0);
    check("busy_idle", 16'(busy), 16'd0);
    check("prod_idle", 16'(product), 16'(last_prod));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_prod   = '0;
    start       = 1'b1;
    a           = 4'hF;
    b           = 4'hF;
    rst_n       = 1'b0;

    // Reset held with start asserted: nothing may begin.
    tick();
    tick();
    check("rst_product", 16'(product), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    start = 1'b0;
    rst_n = 1'b1;
    idle_cycle();

    // Basic, max and zero operands.
    start_op(4'd3, 4'd5);
    check("busy_accept", 16'(busy), 16'd1);
    wait_done(0);
    idle_cycle();
    start_op(4'hF, 4'hF);
    wait_done(0);
    idle_cycle();
    start_op(4'd0, 4'd9);
    wait_done(0);
    idle_cycle();

    // Start during busy is ignored.
    start_op(4'd7, 4'd6);
    wait_done(2);
    idle_cycle();

    // Back-to-back: next start issued in the done cycle.
    start_op(4'd9, 4'd9);
    wait_done(0);
    start_op(4'd4, 4'd3);
    check("b2b_busy", 16'(busy), 16'd1);
    check("b2b_hold", 16'(product), 16'd81);
    wait_done(0);
    idle_cycle();

    // Reset mid-operation aborts with no done pulse.
    start_op(4'd5, 4'd5);
    tick();
    check("abort_busy_pre", 16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    last_prod = '0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_product", 16'(product), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    for (int i = 0; i < WIDTH; i++) idle_cycle();
    start_op(4'd5, 4'd5);
    wait_done(0);
    idle_cycle();

    // Randomized operations with stray starts and back-to-back chaining.
    for (int n = 0; n < 40; n++) begin
      start_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
      wait_done(int'($urandom_range(0, WIDTH - 1)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
